data_mem_requester: RTL and testbench
=====================================

// Module: data_mem_requester
// PURPOSE
//  Initiator side of the data-memory port: takes load/store requests from the 8-bit core's
//  execute stage over a valid/ready handshake and sequences them onto the memory port.
//  One request outstanding at a time. Reads allow a configurable memory read latency.
//  Returns a response (load data or store ack, plus error flag) that is held until accepted.
// PARAMETERS
//  ADDR_W      8    address width
//  DATA_W      8    store data width
//  RDATA_W     16   memory read word width
//  DEPTH       33   number of valid memory words; addresses >= DEPTH are rejected
//  RD_LATENCY  1    cycles from mem_re sample edge to mem_rdata valid; legal range 1..4
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        asynchronous reset, active-low
//  req_valid    in   1        request present
//  req_ready    out  1        block can accept a request
//  req_write    in   1        1 = store, 0 = load
//  req_addr     in   ADDR_W   word address
//  req_wdata    in   DATA_W   store data
//  resp_valid   out  1        response present
//  resp_ready   in   1        consumer takes the response
//  resp_rdata   out  RDATA_W  load data; 0 for stores and for errors
//  resp_err     out  1        address out of range; no memory access was made
//  mem_we       out  1        one-cycle write strobe
//  mem_re       out  1        one-cycle read strobe
//  mem_addr     out  ADDR_W   memory address; held from issue until response
//  mem_wdata    out  DATA_W   memory write data
//  mem_rdata    in   RDATA_W  memory read data
//  err_cnt      out  8        count of rejected requests; saturates at 255
// BEHAVIOUR
//  - All outputs are registered. Async reset clears every output to 0 and the FSM to IDLE
//    in the same instant; reset mid-operation drops the transaction (no strobe, no response).
//  - req_ready = (state == IDLE). A request is accepted on an edge where req_valid && req_ready.
//    Request fields are captured only at acceptance.
//  - FSM: IDLE -> ERR   if req_addr >= DEPTH
//         IDLE -> WR    store in range: mem_we = 1, addr/wdata driven for exactly 1 cycle
//         IDLE -> RD    load in range: mem_re = 1 for 1 cycle, then wait for read data
//         WR -> RESP;  ERR -> RESP;  RD -> RESP after lat_cnt reaches RD_LATENCY, capturing mem_rdata
//         RESP -> IDLE on resp_valid && resp_ready
//  - Timing, request accepted at edge 0:
//    store: mem_we high in cycle 1; resp_valid from cycle 2.
//    load:  mem_re high in cycle 1; mem_rdata sampled at the end of cycle 1+RD_LATENCY;
//           resp_valid from cycle 2+RD_LATENCY.
//    error: no strobe; resp_valid from cycle 1 with resp_err = 1 and resp_rdata = 0.
//  - resp_* are stable while resp_valid && !resp_ready.
//  - After acceptance the next request can be accepted at the earliest one cycle after
//    the response handshake, because req_ready rises only in IDLE.
//  - mem_we and mem_re are never both high. Outside WR and RD they are 0.
//  - mem_addr and mem_wdata hold their last values in IDLE; they do not return to 0.
//  - Boundaries: address DEPTH-1 is legal and address DEPTH is an error.
//    err_cnt increments once per rejected request, holds at 255, and is cleared only by reset.
//    lat_cnt is wide enough to count to 4.
//  - resp_ready asserted while not in RESP is ignored.
// STRUCTURE
//  - Shared package dmem_pkg: state encoding (IDLE, WR, RD, ERR, RESP), DEPTH default,
//    and an RD_LATENCY range check constant.
//  - Single module; no sub-module is needed. lat_cnt and err_cnt are inline registers.
// TESTING
//  1. Store at addr 0x05 with data 0xA5 -> mem_we = 1 for exactly cycle 1 with addr 0x05 and
//     wdata 0xA5; resp_valid in cycle 2 with err = 0 and rdata = 0.
//  2. Load at addr 0x05 with RD_LATENCY = 1 and memory returning 0x00A5 -> mem_re in cycle 1;
//     resp_valid in cycle 3 with resp_rdata = 0x00A5. Repeat with RD_LATENCY = 3:
//     resp_valid in cycle 5.
//  3. Load at addr 32 (legal) and then addr 33 -> the first accesses memory; the second gives
//     no strobe, resp_err = 1 in cycle 1, and err_cnt = 1.
//  4. Hold resp_ready = 0 for 10 cycles after a load -> resp_* stay stable, req_ready = 0,
//     and no new strobe occurs. Then assert resp_ready -> req_ready = 1 on the next cycle.
//  5. Assert rst_n = 0 during the RD wait -> all outputs are 0 immediately. After release
//     there is no stale response, and a fresh store completes normally.
//  6. Issue 300 out-of-range requests back-to-back -> err_cnt saturates at 255.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory requester: FSM encoding, default depth
// and the legal read-latency window.
package dmem_pkg;

  localparam int unsigned DMEM_DEPTH = 33;
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 4;
  localparam int unsigned LAT_W      = 3;
  localparam int unsigned ERR_CNT_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WR   = 3'd1,
    ST_RD   = 3'd2,
    ST_ERR  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  function automatic bit rd_latency_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/data_mem_requester.sv
// Sequences one load/store at a time from the execute stage onto the data-memory
// port and returns a held response; out-of-range addresses are rejected and counted.
module data_mem_requester
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned RDATA_W    = 16,
  parameter int unsigned DEPTH      = DMEM_DEPTH,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RDATA_W-1:0]   resp_rdata,
  output logic                 resp_err,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic [RDATA_W-1:0]   mem_rdata,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
    $error("data_mem_requester: RD_LATENCY outside 1..4");
  end

  state_t               state, state_n;
  logic [LAT_W-1:0]     lat_cnt, lat_cnt_n;
  logic                 req_ready_n, resp_valid_n, resp_err_n, mem_we_n, mem_re_n;
  logic [RDATA_W-1:0]   resp_rdata_n;
  logic [ADDR_W-1:0]    mem_addr_n;
  logic [DATA_W-1:0]    mem_wdata_n;
  logic [ERR_CNT_W-1:0] err_cnt_n;
  logic                 accept, addr_bad;

  assign accept   = req_valid && req_ready;
  assign addr_bad = 32'(req_addr) >= DEPTH;

  // State and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_n;
      lat_cnt    <= lat_cnt_n;
      req_ready  <= req_ready_n;
      resp_valid <= resp_valid_n;
      resp_rdata <= resp_rdata_n;
      resp_err   <= resp_err_n;
      mem_we     <= mem_we_n;
      mem_re     <= mem_re_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      err_cnt    <= err_cnt_n;
    end
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_n      = state;
    lat_cnt_n    = lat_cnt;
    resp_valid_n = resp_valid;
    resp_rdata_n = resp_rdata;
    resp_err_n   = resp_err;
    mem_we_n     = 1'b0;
    mem_re_n     = 1'b0;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    err_cnt_n    = err_cnt;

    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (addr_bad) begin
            // Error response is visible the cycle right after acceptance
            state_n      = ST_ERR;
            resp_valid_n = 1'b1;
            resp_err_n   = 1'b1;
            resp_rdata_n = '0;
            if (err_cnt != '1) err_cnt_n = err_cnt + ERR_CNT_W'(1);
          end else if (req_write) begin
            state_n     = ST_WR;
            mem_we_n    = 1'b1;
            mem_addr_n  = req_addr;
            mem_wdata_n = req_wdata;
          end else begin
            state_n    = ST_RD;
            mem_re_n   = 1'b1;
            mem_addr_n = req_addr;
            lat_cnt_n  = '0;
          end
        end
      end
      ST_WR: begin
        state_n      = ST_RESP;
        resp_valid_n = 1'b1;
        resp_err_n   = 1'b0;
        resp_rdata_n = '0;
      end
      ST_RD: begin
        if (lat_cnt == LAT_W'(RD_LATENCY)) begin
          state_n      = ST_RESP;
          resp_valid_n = 1'b1;
          resp_err_n   = 1'b0;
          resp_rdata_n = mem_rdata;
        end else begin
          lat_cnt_n = lat_cnt + LAT_W'(1);
        end
      end
      ST_ERR: begin
        // resp_valid is already high here, so a ready consumer completes the handshake
        if (resp_ready) begin
          state_n      = ST_IDLE;
          resp_valid_n = 1'b0;
        end else begin
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_n      = ST_IDLE;
          resp_valid_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    req_ready_n = (state_n == ST_IDLE);
  end

endmodule

// File: tb/tb_data_mem_requester.sv
// Randomized self-checking bench for data_mem_requester against a transaction-level
// model: expected latency, response data, strobes and error count per request.
module tb_data_mem_requester;

  localparam int unsigned DEPTH = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid = 1'b0, req_valid3 = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        resp_ready = 1'b0, resp_ready3 = 1'b0;

  logic        req_ready, resp_valid, resp_err, mem_we, mem_re;
  logic [15:0] resp_rdata, mem_rdata;
  logic [7:0]  mem_addr, mem_wdata, err_cnt;

  logic        req_ready3, resp_valid3, resp_err3, mem_we3, mem_re3;
  logic [15:0] resp_rdata3, mem_rdata3;
  logic [7:0]  mem_addr3, mem_wdata3, err_cnt3;

  logic [15:0] mem_model [0:255];
  logic [15:0] ref_mem   [0:255];
  int          ref_err_cnt = 0;
  int          rd_age = 0, rd_age3 = 0;
  int          we_total = 0, re_total = 0, both_total = 0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  data_mem_requester #(.RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_cnt(err_cnt));

  data_mem_requester #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid3), .resp_ready(resp_ready3), .resp_rdata(resp_rdata3),
    .resp_err(resp_err3), .mem_we(mem_we3), .mem_re(mem_re3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3), .err_cnt(err_cnt3));

  // Memory: data is valid only in the cycle the requester must sample it
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_age  <= 0;
      rd_age3 <= 0;
    end else begin
      rd_age  <= mem_re  ? 1 : (rd_age  != 0 ? rd_age  + 1 : 0);
      rd_age3 <= mem_re3 ? 1 : (rd_age3 != 0 ? rd_age3 + 1 : 0);
      if (mem_we) mem_model[mem_addr] <= {8'h00, mem_wdata};
      if (mem_we) we_total <= we_total + 1;
      if (mem_re) re_total <= re_total + 1;
      if (mem_we && mem_re) both_total <= both_total + 1;
    end
  end
  assign mem_rdata  = (rd_age  == 1) ? mem_model[mem_addr]  : 16'hDEAD;
  assign mem_rdata3 = (rd_age3 == 3) ? mem_model[mem_addr3] : 16'hBEEF;

  task automatic drive_req(input logic w, input logic [7:0] a, input logic [7:0] d,
                           output int lat, output logic [15:0] rd, output logic e,
                           output int nwe, output int nre, output bit to);
    int we0, re0, t;
    we0 = we_total; re0 = re_total; to = 1'b0; t = 0; lat = 0; rd = '0; e = 1'b0;
    nwe = 0; nre = 0;
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    while (req_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    if (req_ready !== 1'b1) begin to = 1'b1; req_valid = 1'b0; return; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (resp_valid !== 1'b1 && lat < 20) begin @(negedge clk); lat++; end
    if (resp_valid !== 1'b1) to = 1'b1;
    rd = resp_rdata; e = resp_err;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    nwe = we_total - we0; nre = re_total - re0;
  endtask

  function automatic void note_error();
    if (ref_err_cnt < 255) ref_err_cnt++;
  endfunction

  task automatic test_reset();
    logic [63:0] all_out;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    all_out = {req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_re,
               mem_addr, mem_wdata, err_cnt};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0", all_out);
    end
    rst_n = 1'b1;
    ref_err_cnt = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || req_ready3 !== 1'b1) begin
      errors++; $display("FAIL reset_ready got %b/%b want 1/1", req_ready, req_ready3);
    end
  endtask

  task automatic test_store();
    req_write = 1'b1; req_addr = 8'h05; req_wdata = 8'hA5; req_valid = 1'b1;
    resp_ready = 1'b1;  // held early: must be ignored until the response exists
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if ({mem_we, mem_re, mem_addr, mem_wdata, resp_valid, req_ready} !== {1'b1, 1'b0, 8'h05, 8'hA5, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL store_cycle1 got we=%b re=%b addr=%h wdata=%h rv=%b rr=%b want 1 0 05 a5 0 0",
               mem_we, mem_re, mem_addr, mem_wdata, resp_valid, req_ready);
    end
    @(negedge clk);
    checks++;
    if ({mem_we, resp_valid, resp_err, resp_rdata} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL store_cycle2 got we=%b rv=%b err=%b rdata=%h want 0 1 0 0000",
               mem_we, resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if ({resp_valid, req_ready, mem_addr, mem_wdata} !== {1'b0, 1'b1, 8'h05, 8'hA5}) begin
      errors++;
      $display("FAIL store_cycle3 got rv=%b rr=%b addr=%h wdata=%h want 0 1 05 a5",
               resp_valid, req_ready, mem_addr, mem_wdata);
    end
    ref_mem[5] = 16'h00A5;
  endtask

  task automatic test_load_latency();
    int lat, nwe, nre, t;
    logic [15:0] rd;
    logic e;
    bit to, re_seen;
    drive_req(1'b0, 8'h05, 8'h00, lat, rd, e, nwe, nre, to);
    checks++;
    if (to || lat != 3 || rd !== 16'h00A5 || e !== 1'b0 || nre != 1 || nwe != 0) begin
      errors++;
      $display("FAIL load_lat1 got to=%0d lat=%0d rdata=%h err=%b re=%0d we=%0d want 0 3 00a5 0 1 0",
               to, lat, rd, e, nre, nwe);
    end
    // RD_LATENCY = 3 instance
    req_write = 1'b0; req_addr = 8'h05; req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    re_seen = (mem_re3 === 1'b1) && (mem_we3 === 1'b0);
    t = 1;
    while (resp_valid3 !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (!re_seen || t != 5 || resp_rdata3 !== 16'h00A5 || resp_err3 !== 1'b0) begin
      errors++;
      $display("FAIL load_lat3 got re1=%0d lat=%0d rdata=%h err=%b want 1 5 00a5 0",
               re_seen, t, resp_rdata3, resp_err3);
    end
    resp_ready3 = 1'b1;
    @(negedge clk);
    resp_ready3 = 1'b0;
  endtask

  task automatic test_boundary();
    int lat, nwe, nre;
    logic [15:0] rd;
    logic e;
    bit to;
    drive_req(1'b0, 8'(DEPTH - 1), 8'h00, lat, rd, e, nwe, nre, to);
    checks++;
    if (to || lat != 3 || rd !== ref_mem[DEPTH-1] || e !== 1'b0 || nre != 1) begin
      errors++;
      $display("FAIL bound_last got to=%0d lat=%0d rdata=%h err=%b re=%0d want 0 3 %h 0 1",
               to, lat, rd, e, nre, ref_mem[DEPTH-1]);
    end
    drive_req(1'b0, 8'(DEPTH), 8'h00, lat, rd, e, nwe, nre, to);
    note_error();
    checks++;
    if (to || lat != 1 || rd !== 16'h0000 || e !== 1'b1 || nre != 0 || nwe != 0 ||
        32'(err_cnt) != ref_err_cnt) begin
      errors++;
      $display("FAIL bound_depth got to=%0d lat=%0d rdata=%h err=%b re=%0d we=%0d cnt=%0d want 0 1 0000 1 0 0 %0d",
               to, lat, rd, e, nre, nwe, err_cnt, ref_err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] a;
    logic [15:0] rd0;
    logic e0;
    int t, we0, re0;
    bit stable;
    a = 8'($urandom_range(0, DEPTH - 1));
    req_write = 1'b0; req_addr = a; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t = 1;
    while (resp_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    rd0 = resp_rdata; e0 = resp_err; we0 = we_total; re0 = re_total; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== e0 || req_ready !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable || t != 3 || rd0 !== ref_mem[a] || e0 !== 1'b0 ||
        we_total != we0 || re_total != re0) begin
      errors++;
      $display("FAIL backpressure got stable=%0d lat=%0d rdata=%h err=%b strobes=%0d want 1 3 %h 0 0",
               stable, t, rd0, e0, (we_total - we0) + (re_total - re0), ref_mem[a]);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release got rr=%b rv=%b want 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_random();
    int lat, nwe, nre, exp_lat, exp_we, exp_re;
    logic [15:0] rd, exp_rd;
    logic e, exp_e, w;
    logic [7:0] a, d;
    bit to;
    int both0;
    both0 = both_total;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(DEPTH, 255))
                                      : 8'($urandom_range(0, DEPTH - 1));
      d = 8'($urandom);
      if (32'(a) >= DEPTH) begin
        exp_lat = 1; exp_rd = '0; exp_e = 1'b1; exp_we = 0; exp_re = 0;
        note_error();
      end else if (w) begin
        exp_lat = 2; exp_rd = '0; exp_e = 1'b0; exp_we = 1; exp_re = 0;
        ref_mem[a] = {8'h00, d};
      end else begin
        exp_lat = 3; exp_rd = ref_mem[a]; exp_e = 1'b0; exp_we = 0; exp_re = 1;
      end
      drive_req(w, a, d, lat, rd, e, nwe, nre, to);
      checks++;
      if (to || lat != exp_lat || rd !== exp_rd || e !== exp_e || nwe != exp_we ||
          nre != exp_re || 32'(err_cnt) != ref_err_cnt) begin
        errors++;
        $display("FAIL random[%0d] w=%b a=%h got to=%0d lat=%0d rd=%h err=%b we=%0d re=%0d cnt=%0d want 0 %0d %h %b %0d %0d %0d",
                 i, w, a, to, lat, rd, e, nwe, nre, err_cnt,
                 exp_lat, exp_rd, exp_e, exp_we, exp_re, ref_err_cnt);
      end
    end
    checks++;
    if (both_total != both0) begin
      errors++; $display("FAIL strobe_overlap got %0d cycles want 0", both_total - both0);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, nwe, nre, stale;
    logic [15:0] rd;
    logic e;
    logic [7:0] a;
    logic [63:0] all_out;
    bit to;
    req_write = 1'b0; req_addr = 8'h07; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    all_out = {req_ready, resp_valid, resp_rdata, resp_err, mem_we, mem_re,
               mem_addr, mem_wdata, err_cnt};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_mid_outputs got %h want 0", all_out);
    end
    ref_err_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || mem_re !== 1'b0) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++; $display("FAIL reset_mid_stale got %0d cycles want 0", stale);
    end
    a = 8'($urandom_range(0, DEPTH - 1));
    ref_mem[a] = 16'h005A;
    drive_req(1'b1, a, 8'h5A, lat, rd, e, nwe, nre, to);
    checks++;
    if (to || lat != 2 || rd !== 16'h0000 || e !== 1'b0 || nwe != 1 || nre != 0) begin
      errors++;
      $display("FAIL reset_mid_store got to=%0d lat=%0d rd=%h err=%b we=%0d re=%0d want 0 2 0000 0 1 0",
               to, lat, rd, e, nwe, nre);
    end
    drive_req(1'b0, a, 8'h00, lat, rd, e, nwe, nre, to);
    checks++;
    if (to || lat != 3 || rd !== 16'h005A || e !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_readback got to=%0d lat=%0d rd=%h err=%b want 0 3 005a 0",
               to, lat, rd, e);
    end
  endtask

  task automatic test_back_to_back_errors();
    int lat, nwe, nre, bad;
    logic [15:0] rd;
    logic e;
    bit to;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      drive_req(1'($urandom_range(0, 1)), 8'($urandom_range(DEPTH, 255)), 8'($urandom),
                lat, rd, e, nwe, nre, to);
      note_error();
      if (to || e !== 1'b1 || lat != 1 || nwe != 0 || nre != 0) bad++;
      if (i == 250) begin
        checks++;
        if (32'(err_cnt) != ref_err_cnt) begin
          errors++; $display("FAIL err_cnt_mid got %0d want %0d", err_cnt, ref_err_cnt);
        end
      end
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL b2b_err_resp got %0d bad want 0", bad);
    end
    checks++;
    if (err_cnt !== 8'd255 || ref_err_cnt != 255) begin
      errors++; $display("FAIL err_cnt_sat got %0d want 255", err_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_model[i] = 16'($urandom);
      ref_mem[i]   = mem_model[i];
    end
    test_reset();
    test_store();
    test_load_latency();
    test_boundary();
    test_backpressure();
    test_random();
    test_reset_mid_read();
    test_back_to_back_errors();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
